// File: rtl/memory_game_fsm.sv
// Memory-game sequencer: button conditioning, 5x4 cursor, pick/compare/show/won flow.
// Optional MEMORY_GAME_DEBOUNCE_EN adds a per-button stability filter ahead of edge detection.
`timescale 1ns/1ps
module memory_game_fsm #(
  parameter int unsigned NUM_CARDS       = 20,
  parameter int unsigned COLS            = 5,
  parameter int unsigned ROWS            = 4,
  parameter int unsigned REVEAL_FRAMES   = 60,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                   clock_50M,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic                   move_x,
  input  logic                   move_y,
  input  logic                   select,
  input  logic [NUM_CARDS*5-1:0] card_ids,
  output logic [4:0]             cursor,
  output logic [NUM_CARDS-1:0]   revealed,
  output logic [NUM_CARDS-1:0]   matched,
  output logic [3:0]             match_count,
  output logic [7:0]             attempts,
  output logic                   game_won
);

  localparam int unsigned ID_W  = 5;
  localparam int unsigned POS_W = 5;
  localparam int unsigned COL_W = 3;
  localparam int unsigned ROW_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ATT_W = 8;
  localparam int unsigned FRM_W = $clog2(REVEAL_FRAMES + 1);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BX    = 0;
  localparam int unsigned BY    = 1;
  localparam int unsigned BS    = 2;

  typedef enum logic [2:0] {PICK1, PICK2, COMPARE, SHOW, WON} state_t;

  logic [2:0] raw, sync1_q, sync2_q, level, prev_q, pulse_q;

  assign raw = {select, move_y, move_x};

  // Synchronizer plus registered rising-edge detector
  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= level;
      pulse_q <= level & ~prev_q;
    end
  end

`ifdef MEMORY_GAME_DEBOUNCE_EN
  logic [2:0]      level_q;
  logic [DB_W-1:0] db_cnt_q [3];

  // Accept a new level only after it has held for the full window
  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign level = level_q;
`else
  logic [DB_W-1:0] db_width_unused;
  assign db_width_unused = '0;
  assign level = sync2_q;
`endif

  // Pair identity is the card id without its lsb
  logic [ID_W-2:0]      pair_id [NUM_CARDS];
  logic [NUM_CARDS-1:0] id_lsb_unused;

  for (genvar g = 0; g < NUM_CARDS; g++) begin : g_pair
    assign pair_id[g]       = card_ids[ID_W*g+1 +: ID_W-1];
    assign id_lsb_unused[g] = card_ids[ID_W*g];
  end

  state_t               state_q, state_n;
  logic [COL_W-1:0]     col_q, col_n;
  logic [ROW_W-1:0]     row_q, row_n;
  logic [POS_W-1:0]     first_q, first_n, second_q, second_n, cursor_n;
  logic [NUM_CARDS-1:0] revealed_n, matched_n;
  logic [CNT_W-1:0]     match_count_n;
  logic [ATT_W-1:0]     attempts_n;
  logic [FRM_W-1:0]     frm_q, frm_n;
  logic                 game_won_n;
  logic                 free_c;

  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PICK1;
      col_q       <= '0;
      row_q       <= '0;
      cursor      <= '0;
      first_q     <= '0;
      second_q    <= '0;
      revealed    <= '0;
      matched     <= '0;
      match_count <= '0;
      attempts    <= '0;
      frm_q       <= '0;
      game_won    <= 1'b0;
    end else begin
      state_q     <= state_n;
      col_q       <= col_n;
      row_q       <= row_n;
      cursor      <= cursor_n;
      first_q     <= first_n;
      second_q    <= second_n;
      revealed    <= revealed_n;
      matched     <= matched_n;
      match_count <= match_count_n;
      attempts    <= attempts_n;
      frm_q       <= frm_n;
      game_won    <= game_won_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    col_n         = col_q;
    row_n         = row_q;
    first_n       = first_q;
    second_n      = second_q;
    revealed_n    = revealed;
    matched_n     = matched;
    match_count_n = match_count;
    attempts_n    = attempts;
    frm_n         = frm_q;

    // Cursor moves in every state; select below still uses the pre-move cursor
    if (pulse_q[BY]) row_n = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
    if (pulse_q[BX]) col_n = (col_q == '0) ? COL_W'(COLS - 1) : col_q - 1'b1;
    cursor_n = POS_W'(ROWS) * POS_W'(col_n) + POS_W'(row_n);

    free_c = !matched[cursor] && !revealed[cursor];

    case (state_q)
      PICK1: begin
        if (pulse_q[BS] && free_c) begin
          revealed_n[cursor] = 1'b1;
          first_n            = cursor;
          state_n            = PICK2;
        end
      end
      PICK2: begin
        if (pulse_q[BS] && free_c && (cursor != first_q)) begin
          revealed_n[cursor] = 1'b1;
          second_n           = cursor;
          attempts_n         = (attempts == '1) ? attempts : attempts + 1'b1;
          state_n            = COMPARE;
        end
      end
      COMPARE: begin
        if (pair_id[first_q] == pair_id[second_q]) begin
          matched_n[first_q]   = 1'b1;
          matched_n[second_q]  = 1'b1;
          revealed_n[first_q]  = 1'b0;
          revealed_n[second_q] = 1'b0;
          match_count_n        = match_count + 1'b1;
          state_n = (match_count_n == CNT_W'(NUM_CARDS / 2)) ? WON : PICK1;
        end else begin
          frm_n   = '0;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (frame_tick) begin
          if (frm_q + 1'b1 == FRM_W'(REVEAL_FRAMES)) begin
            revealed_n[first_q]  = 1'b0;
            revealed_n[second_q] = 1'b0;
            state_n              = PICK1;
          end else begin
            frm_n = frm_q + 1'b1;
          end
        end
      end
      WON: begin
        if (pulse_q[BS]) begin
          revealed_n    = '0;
          matched_n     = '0;
          match_count_n = '0;
          attempts_n    = '0;
          state_n       = PICK1;
        end
      end
      default: state_n = PICK1;
    endcase

    game_won_n = (state_n == WON);
  end

endmodule

// File: tb/tb_memory_game_fsm.sv
// Directed bench for memory_game_fsm: cursor wrap, match, mismatch timing, illegal picks,
// win/restart, async reset, attempts saturation and (with MEMORY_GAME_DEBOUNCE_EN) glitch rejection.
`timescale 1ns/1ps
module tb_memory_game_fsm;

  localparam int unsigned NC = 20;
  localparam int unsigned RF = 3;
  localparam int unsigned DB = 8;
`ifdef MEMORY_GAME_DEBOUNCE_EN
  localparam int HOLD = 20;
  localparam int GAP  = 20;
`else
  localparam int HOLD = 4;
  localparam int GAP  = 6;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          move_x = 1'b0;
  logic          move_y = 1'b0;
  logic          select = 1'b0;
  logic [NC*5-1:0] card_ids;
  logic [4:0]    cursor;
  logic [NC-1:0] revealed, matched;
  logic [3:0]    match_count;
  logic [7:0]    attempts;
  logic          game_won;

  int vectors = 0;
  int miscompares = 0;
  int m_col = 0;
  int m_row = 0;
  int pair_tab [20] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 5, 4, 6, 6, 7, 7, 8, 5, 8, 9, 9};
  int win_a [8] = '{2, 4, 6, 8, 11, 13, 15, 18};
  int win_b [8] = '{3, 5, 7, 10, 12, 14, 17, 19};

  memory_game_fsm #(
    .NUM_CARDS(NC), .COLS(5), .ROWS(4), .REVEAL_FRAMES(RF), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock_50M(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .move_x(move_x), .move_y(move_y), .select(select), .card_ids(card_ids),
    .cursor(cursor), .revealed(revealed), .matched(matched),
    .match_count(match_count), .attempts(attempts), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input int b);
    @(posedge clk); #1;
    if (b == 0) move_x = 1'b1; else if (b == 1) move_y = 1'b1; else select = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1;
    move_x = 1'b0; move_y = 1'b0; select = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    if (b == 0) m_col = (m_col == 0) ? 4 : m_col - 1;
    if (b == 1) m_row = (m_row + 1) % 4;
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic goto_pos(input int pos);
    while (m_col != pos / 4) press(0);
    while (m_row != pos % 4) press(1);
  endtask

  function automatic logic [NC-1:0] bit2(input int a, input int b);
    logic [NC-1:0] v;
    v = '0;
    v[a] = 1'b1;
    v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] m_exp;
    for (int k = 0; k < NC; k++) card_ids[k*5 +: 5] = 5'(pair_tab[k] * 2 + k % 2);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cursor", 32'(cursor), 0);
    check("rst_revealed", 32'(revealed), 0);
    check("rst_matched", 32'(matched), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_attempts", 32'(attempts), 0);
    check("rst_won", 32'(game_won), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    press(1); check("move_y_1", 32'(cursor), 1);
    press(1); check("move_y_2", 32'(cursor), 2);
    press(1); check("move_y_3", 32'(cursor), 3);
    press(1); check("move_y_wrap", 32'(cursor), 0);
    press(0); check("move_x_wrap", 32'(cursor), 16);

    // One long hold must move only once
    @(posedge clk); #1 move_y = 1'b1;
    repeat (40) @(posedge clk);
    #1 move_y = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
    m_row = 1;
    check("hold_once", 32'(cursor), 17);

    goto_pos(9); press(2);
    check("pick_9", 32'(revealed), 32'(bit2(9, 9)));
    goto_pos(16); press(2);
    m_exp = bit2(9, 16);
    check("match_mask", 32'(matched), 32'(m_exp));
    check("match_rev", 32'(revealed), 0);
    check("match_count1", 32'(match_count), 1);
    check("match_att1", 32'(attempts), 1);

    goto_pos(0); press(2);
    goto_pos(2); press(2);
    check("mis_rev", 32'(revealed), 32'(bit2(0, 2)));
    check("mis_att", 32'(attempts), 2);
    tick(); tick();
    check("show_tick2", 32'(revealed), 32'(bit2(0, 2)));
    press(2);
    goto_pos(3); press(2);
    check("show_sel_rev", 32'(revealed), 32'(bit2(0, 2)));
    check("show_sel_att", 32'(attempts), 2);
    check("show_sel_mat", 32'(matched), 32'(m_exp));
    tick();
    check("show_tick3", 32'(revealed), 0);

    goto_pos(0); press(2);
    press(2);
    check("resel_first_rev", 32'(revealed), 32'(bit2(0, 0)));
    check("resel_first_att", 32'(attempts), 2);
    goto_pos(9); press(2);
    check("sel_matched_rev", 32'(revealed), 32'(bit2(0, 0)));
    check("sel_matched_att", 32'(attempts), 2);
    goto_pos(1); press(2);
    m_exp = m_exp | bit2(0, 1);
    check("match2_mask", 32'(matched), 32'(m_exp));
    check("match2_count", 32'(match_count), 2);
    check("match2_att", 32'(attempts), 3);
    check("match2_won", 32'(game_won), 0);

    for (int p = 0; p < 8; p++) begin
      goto_pos(win_a[p]); press(2);
      goto_pos(win_b[p]); press(2);
    end
    check("win_won", 32'(game_won), 1);
    check("win_count", 32'(match_count), 10);
    check("win_mask", 32'(matched), 32'h000F_FFFF);
    check("win_rev", 32'(revealed), 0);
    check("win_att", 32'(attempts), 11);

    press(2);
    check("restart_won", 32'(game_won), 0);
    check("restart_count", 32'(match_count), 0);
    check("restart_att", 32'(attempts), 0);
    check("restart_mask", 32'(matched), 0);
    check("restart_cursor", 32'(cursor), 19);
    press(2);
    check("restart_pick1", 32'(revealed), 32'(bit2(19, 19)));

    // Asynchronous reset mid-game, observed before any clock edge
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("async_rst_rev", 32'(revealed), 0);
    check("async_rst_cursor", 32'(cursor), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_col = 0; m_row = 0;
    repeat (2) @(posedge clk);
    #1;

`ifdef MEMORY_GAME_DEBOUNCE_EN
    @(posedge clk); #1 select = 1'b1;
    repeat (5) @(posedge clk);
    #1 select = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("db_glitch", 32'(revealed), 0);
    press(2);
    check("db_press", 32'(revealed), 32'(bit2(0, 0)));
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 256; i++) begin
      press(2); press(1); press(1); press(2);
      tick(); tick(); tick();
      press(1); press(1);
      if (i == 253) check("att_254", 32'(attempts), 254);
    end
    check("att_sat", 32'(attempts), 255);
    check("att_sat_rev", 32'(revealed), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_game_fsm.md
# memory_game_fsm

Game-sequencing controller for the 20-card memory game. Converts the raw `move_x`, `move_y` and `select` buttons into single-cycle actions and keeps the cursor on the 5×4 grid. It runs the pick-first / pick-second / compare / show-mismatch cycle and tracks which cards are revealed or matched. The VGA renderer in `pepinosDigitais` consumes `cursor`, `revealed` and `matched` to choose between a card's face colour, its back and the cursor marker.

## Interface
Parameters:
- `NUM_CARDS`, 20: cards on the board; always even, always COLS×ROWS.
- `COLS`, 5: grid columns.
- `ROWS`, 4: grid rows. Position index = ROWS×col + row.
- `REVEAL_FRAMES`, 60: frames a mismatched pair stays visible.
- `DEBOUNCE_CYCLES`, 500000: stability window in clock cycles; used only with `DEBOUNCE_EN`.

Ports:
- `clock_50M` input 1: the single clock. All logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `frame_tick` input 1: one-cycle pulse per video frame, synchronous to `clock_50M`.
- `move_x` input 1: raw button; each press moves the cursor one column left, with wrap.
- `move_y` input 1: raw button; each press moves the cursor one row down, with wrap.
- `select` input 1: raw button; each press picks the card under the cursor, or restarts the game after a win.
- `card_ids` input NUM_CARDS×5: card identity per position, 5 bits per position, position k at bits [5k+4:5k]. Two cards form a pair when their ids are equal after `id>>1`.
- `cursor` output 5: current position index.
- `revealed` output NUM_CARDS: cards currently face-up but not yet matched.
- `matched` output NUM_CARDS: cards permanently matched.
- `match_count` output 4: number of pairs found, 0 to NUM_CARDS/2.
- `attempts` output 8: number of completed pair picks; saturates at 255.
- `game_won` output 1: high while in the WON state.

## Operation
Input conditioning:
- Each button passes through a 2-flop synchronizer, then a rising-edge detector that produces a one-cycle action pulse.
- Holding a button produces exactly one action.

Cursor:
- The cursor is stored as `col` (3 bits) and `row` (2 bits).
- `move_y`: row ← (row+1) mod ROWS.
- `move_x`: col ← col−1, wrapping from 0 to COLS−1.
- Simultaneous `move_x` and `move_y` pulses apply both updates in the same cycle.
- Cursor moves are accepted in every state.

State machine (`PICK1`, `PICK2`, `COMPARE`, `SHOW`, `WON`):
- **PICK1**: on a select pulse with the card under the cursor neither matched nor revealed: set `revealed[cursor]`, latch `first`=cursor, go to PICK2. Otherwise the select is ignored.
- **PICK2**: on a select pulse with cursor ≠ `first` and the card under the cursor neither matched nor revealed: set `revealed[cursor]`, latch `second`, increment `attempts` (saturating), go to COMPARE. Otherwise the select is ignored.
- **COMPARE** (one cycle):
  - If `card_ids[first]>>1 == card_ids[second]>>1`: set both `matched` bits, clear both `revealed` bits, increment `match_count`. If the new count equals NUM_CARDS/2, go to WON; otherwise go to PICK1.
  - Otherwise go to SHOW and clear the frame counter.
- **SHOW**: the frame counter increments on each `frame_tick`. On the tick that brings the count to REVEAL_FRAMES, clear both `revealed` bits and go to PICK1. Select pulses are ignored in this state.
- **WON**: `game_won` is 1. A select pulse clears `revealed`, `matched`, `match_count` and `attempts`, and goes to PICK1. The cursor is kept.

Other rules:
- A select pulse in the same cycle as a move pulse uses the cursor value from before the move.
- `card_ids` is sampled only in COMPARE and must be stable during play.

## Timing
- Reset values: state PICK1, `cursor`=0, `revealed`=0, `matched`=0, `match_count`=0, `attempts`=0, `game_won`=0, frame counter 0, synchronizer and edge registers 0.
- All outputs are registered.
- Latency: a button first sampled high at edge k produces its action pulse after edge k+2. The outputs change at edge k+3.
- COMPARE always lasts exactly one cycle.
- Mismatch display time: exactly REVEAL_FRAMES `frame_tick` pulses, counted from the first tick after COMPARE.
- `reset_n` low at any point, including during SHOW or WON, returns everything to the reset values immediately.
- `attempts` holds at 255 once it reaches 255.

## Configuration
- `MEMORY_GAME_DEBOUNCE_EN` defined:
  - After the synchronizer, each button's accepted level changes only after the synchronized input has held the new value for DEBOUNCE_CYCLES consecutive cycles. The edge detector operates on this accepted level.
  - Latency becomes k+2+DEBOUNCE_CYCLES.
  - Glitches shorter than the window produce no action.
- Not defined: the edge detector operates directly on the synchronized input, and DEBOUNCE_CYCLES is unused.

## Test plan
- **Reset and cursor wrap**: reset, then 4 `move_y` presses → cursor returns to 0. One `move_x` press from 0 → cursor=16.
- **Matching pair**: `card_ids` such that positions 9 and 16 share id>>1. Select 9, move, select 16 → `matched` bits 9 and 16 set, `revealed`=0, `match_count`=1, `attempts`=1.
- **Mismatch and reveal timing**: REVEAL_FRAMES=3; pick a mismatched pair → both `revealed` bits stay 1 through 2 frame ticks and clear on the 3rd; select pulses during SHOW change nothing.
- **Illegal selects**: re-select `first` in PICK2 and select an already matched card → no state change, `attempts` unchanged.
- **Win and restart**: match all 10 pairs → `game_won`=1, `match_count`=10. Then select → all counters and masks return to 0 and the state is PICK1.
- **Debounce** (`MEMORY_GAME_DEBOUNCE_EN`, DEBOUNCE_CYCLES=8): a 5-cycle glitch on `select` → no action; a 20-cycle press → exactly one action.
